// File: rtl/cache_controller_if.sv
// Pipeline MEM-stage and SRAM-controller signals of the cache.
// slave = cache side, master = pipeline/SRAM side.
interface cache_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport slave (
    input  rd_en, wr_en, address, wdata,
    input  sram_rdata, sram_ready,
    output rdata, ready,
    output sram_rd_en, sram_wr_en,
    output sram_address, sram_wdata
  );

  modport master (
    output rd_en, wr_en, address, wdata,
    output sram_rdata, sram_ready,
    input  rdata, ready,
    input  sram_rd_en, sram_wr_en,
    input  sram_address, sram_wdata
  );
endinterface

// File: rtl/cache_controller.sv
// 2-way set-associative write-through data cache, 64 sets x 8B.
// Reads allocate on miss; writes go straight to SRAM.
module cache_controller (
  input logic              clk,
  input logic              rst,
  cache_controller_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WRITE
  } state_e;

  state_e state_q, state_d;

  logic [63:0] v0_q, v1_q, lru_q;
  logic [9:0]  tag0_q [64];
  logic [9:0]  tag1_q [64];
  logic [63:0] dat0_q [64];
  logic [63:0] dat1_q [64];

  logic [5:0]  idx;
  logic [9:0]  tag;
  logic        off;
  logic        hit0, hit1, hit;
  logic [63:0] hit_blk;
  logic        victim;

  logic        fill_en;
  logic        wupd_en;
  logic        touch_en;
  logic        touch_way;

  assign idx = bus.address[8:3];
  assign tag = bus.address[18:9];
  assign off = bus.address[2];

  assign hit0 = v0_q[idx] && (tag0_q[idx] == tag);
  assign hit1 = v1_q[idx] && (tag1_q[idx] == tag);
  assign hit  = hit0 | hit1;
  assign hit_blk = hit1 ? dat1_q[idx] : dat0_q[idx];

  // Fill invalid ways first, otherwise evict the LRU way.
  assign victim = !v0_q[idx] ? 1'b0 :
                  !v1_q[idx] ? 1'b1 : lru_q[idx];

  // Next state, handshake outputs and array update strobes.
  always_comb begin
    state_d          = state_q;
    bus.ready        = 1'b0;
    bus.rdata        = '0;
    bus.sram_rd_en   = 1'b0;
    bus.sram_wr_en   = 1'b0;
    bus.sram_address = bus.address;
    bus.sram_wdata   = bus.wdata;
    fill_en          = 1'b0;
    wupd_en          = 1'b0;
    touch_en         = 1'b0;
    touch_way        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_en) begin
          state_d = WRITE;
        end else if (bus.rd_en) begin
          if (hit) begin
            bus.ready = 1'b1;
            bus.rdata = off ? hit_blk[63:32]
                            : hit_blk[31:0];
            touch_en  = 1'b1;
            touch_way = hit1;
          end else begin
            state_d = RD_MISS;
          end
        end else begin
          bus.ready = 1'b1;
        end
      end
      RD_MISS: begin
        bus.sram_rd_en   = 1'b1;
        bus.sram_address = {bus.address[31:3], 3'b000};
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          bus.rdata = off ? bus.sram_rdata[63:32]
                          : bus.sram_rdata[31:0];
          fill_en   = 1'b1;
          touch_en  = 1'b1;
          touch_way = victim;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        bus.sram_wr_en = 1'b1;
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          wupd_en   = hit;
          touch_en  = hit;
          touch_way = hit1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, valid and LRU bits; cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        if (victim) v1_q[idx] <= 1'b1;
        else        v0_q[idx] <= 1'b1;
      end
      if (touch_en) lru_q[idx] <= ~touch_way;
    end
  end

  // Tag and data arrays; reset only blocks updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (fill_en) begin
        if (victim) begin
          tag1_q[idx] <= tag;
          dat1_q[idx] <= bus.sram_rdata;
        end else begin
          tag0_q[idx] <= tag;
          dat0_q[idx] <= bus.sram_rdata;
        end
      end
      if (wupd_en) begin
        if (hit1) begin
          if (off) dat1_q[idx][63:32] <= bus.wdata;
          else     dat1_q[idx][31:0]  <= bus.wdata;
        end else begin
          if (off) dat0_q[idx][63:32] <= bus.wdata;
          else     dat0_q[idx][31:0]  <= bus.wdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Random + directed bench for cache_controller with
// an LRU-list cache model, SRAM responder and scoreboard.
module tb_cache_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_controller_if bus();

  cache_controller dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    bit        is_rd;
    bit [31:0] rdata;
    int        kind;
    bit [31:0] saddr;
    bit [31:0] swdata;
  } exp_t;

  exp_t sb[$];

  bit [31:0] mem [bit [29:0]];
  int        cnt_m [64];
  bit [9:0]  mru_m [64];
  bit [9:0]  lru_m [64];

  int        got_kind = 0;
  bit [31:0] got_addr;
  bit [31:0] got_wdata;
  bit        hold_sram = 1'b0;

  function automatic bit [31:0] memrd(bit [31:0] a);
    bit [29:0] w;
    w = a[31:2];
    if (mem.exists(w)) return mem[w];
    return ({2'b0, w} * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  function automatic bit m_lookup(int s, bit [9:0] t);
    return (cnt_m[s] >= 1 && mru_m[s] == t) ||
           (cnt_m[s] == 2 && lru_m[s] == t);
  endfunction

  function automatic void m_touch(int s, bit [9:0] t);
    if (cnt_m[s] == 2 && lru_m[s] == t) begin
      lru_m[s] = mru_m[s];
      mru_m[s] = t;
    end
  endfunction

  function automatic void m_insert(int s, bit [9:0] t);
    if (cnt_m[s] == 0) begin
      mru_m[s] = t;
      cnt_m[s] = 1;
    end else begin
      lru_m[s] = mru_m[s];
      mru_m[s] = t;
      cnt_m[s] = 2;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) cnt_m[i] = 0;
  endfunction

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Issue one request; model result goes to the scoreboard.
  task automatic req(bit rd, bit wr, bit [31:0] a,
                     bit [31:0] d);
    exp_t e;
    int   s;
    int   n;
    s = int'(a[8:3]);
    e.is_rd  = rd && !wr;
    e.rdata  = '0;
    e.saddr  = '0;
    e.swdata = '0;
    if (wr) begin
      e.kind   = 2;
      e.saddr  = a;
      e.swdata = d;
      mem[a[31:2]] = d;
      if (m_lookup(s, a[18:9])) m_touch(s, a[18:9]);
    end else begin
      e.rdata = memrd(a);
      if (m_lookup(s, a[18:9])) begin
        e.kind = 0;
        m_touch(s, a[18:9]);
      end else begin
        e.kind  = 1;
        e.saddr = {a[31:3], 3'b000};
        m_insert(s, a[18:9]);
      end
    end
    sb.push_back(e);
    bus.rd_en   = rd;
    bus.wr_en   = wr;
    bus.address = a;
    bus.wdata   = d;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      total++;
      bad++;
      $display("FAIL timeout addr=%h ready=0 want 1", a);
    end
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  // SRAM controller model with random latency.
  initial begin
    int cnt;
    bit busy;
    bit [31:0] base;
    cnt  = 0;
    busy = 1'b0;
    bus.sram_ready = 1'b0;
    bus.sram_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.sram_ready) begin
        bus.sram_ready = 1'b0;
        chk("en_after_pulse",
            {62'b0, bus.sram_rd_en, bus.sram_wr_en}, 64'd0);
      end else if (rst && !hold_sram &&
                   (bus.sram_rd_en || bus.sram_wr_en)) begin
        chk("en_exclusive",
            {63'b0, bus.sram_rd_en && bus.sram_wr_en}, 64'd0);
        if (!busy) begin
          busy      = 1'b1;
          cnt       = $urandom_range(0, 4);
          got_kind  = bus.sram_wr_en ? 2 : 1;
          got_addr  = bus.sram_address;
          got_wdata = bus.sram_wdata;
        end
        if (cnt == 0) begin
          base = {got_addr[31:3], 3'b000};
          bus.sram_rdata = {memrd(base + 32'd4), memrd(base)};
          bus.sram_ready = 1'b1;
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Scoreboard monitor: compare on every completed request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (bus.rd_en || bus.wr_en) && bus.ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready got=1 want 0");
        end else begin
          e = sb.pop_front();
          chk("sram_kind", 64'(got_kind), 64'(e.kind));
          if (e.kind != 0)
            chk("sram_addr", {32'b0, got_addr}, {32'b0, e.saddr});
          if (e.kind == 2)
            chk("sram_wdata", {32'b0, got_wdata},
                {32'b0, e.swdata});
          if (e.is_rd)
            chk("rdata", {32'b0, bus.rdata}, {32'b0, e.rdata});
          got_kind = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] a;
    int r;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.address = '0;
    bus.wdata   = '0;
    m_reset();
    mem[30'h100] = 32'h33334444;
    mem[30'h101] = 32'h11112222;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", {63'b0, bus.ready}, 64'd1);
    chk("rst_rdata", {32'b0, bus.rdata}, 64'd0);
    chk("rst_sram_rd", {63'b0, bus.sram_rd_en}, 64'd0);
    chk("rst_sram_wr", {63'b0, bus.sram_wr_en}, 64'd0);
    @(posedge clk);
    #1;

    req(1'b1, 1'b0, 32'h400, 32'h0);
    req(1'b1, 1'b0, 32'h404, 32'h0);
    req(1'b1, 1'b0, 32'h600, 32'h0);
    req(1'b1, 1'b0, 32'h400, 32'h0);
    req(1'b1, 1'b0, 32'hA00, 32'h0);
    req(1'b1, 1'b0, 32'h400, 32'h0);
    req(1'b1, 1'b0, 32'h600, 32'h0);
    req(1'b0, 1'b1, 32'h400, 32'hDEADBEEF);
    req(1'b1, 1'b0, 32'h400, 32'h0);
    req(1'b0, 1'b1, 32'h800, 32'hCAFE0001);
    req(1'b1, 1'b0, 32'h800, 32'h0);
    req(1'b1, 1'b1, 32'h400, 32'h12345678);
    req(1'b1, 1'b0, 32'h400, 32'h0);

    for (int i = 0; i < 300; i++) begin
      a = '0;
      a[18:9] = 10'($urandom_range(0, 3));
      a[8:3]  = 6'($urandom_range(0, 3));
      a[2:0]  = 3'($urandom);
      r = $urandom_range(0, 9);
      req(r != 0 && r != 1 && r != 2, r < 4, a, $urandom);
    end

    hold_sram   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.address = 32'h0007_FFF8;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_sram_rd_on", {63'b0, bus.sram_rd_en}, 64'd1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.rd_en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_sram_rd_off", {63'b0, bus.sram_rd_en}, 64'd0);
    chk("abort_ready", {63'b0, bus.ready}, 64'd1);
    rst       = 1'b1;
    hold_sram = 1'b0;
    got_kind  = 0;
    m_reset();
    @(posedge clk);
    #1;
    req(1'b1, 1'b0, 32'h0007_FFF8, 32'h0);
    req(1'b1, 1'b0, 32'h400, 32'h0);
    req(1'b1, 1'b0, 32'h404, 32'h0);

    repeat (4) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
